keypad_scanner: RTL and testbench

//   Input-side counterpart to the multiplexed 7-seg digit scanner: drives a 4x4 key matrix row by row
//   (active-low), samples the column returns, debounces, and presents one 4-bit key code with a

---
 rtl/keypad_scanner.sv | 157 +++++++++++++++
 tb/tb_keypad_scanner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner with per-strobe debounce
// and a valid/ack key handshake with a sticky overrun flag.
module keypad_scanner #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [3:0] col_in,
  input  logic       key_ack,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       overrun
);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam logic [3:0] NCNT = 4'(DEBOUNCE_SCANS);

  logic [3:0] sync1;
  logic [3:0] sync2;
  state_t     state;
  state_t     state_n;
  logic [1:0] row;
  logic [1:0] row_n;
  logic [1:0] col;
  logic [1:0] col_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic [3:0] cnt_inc;
  logic       latch;
  logic       any_low;
  logic [1:0] low_col;
  logic       col_hi;

  assign row_out = ~(4'b0001 << row);
  assign any_low = ~&sync2;
  assign col_hi  = sync2[col];
  assign cnt_inc = cnt + 4'd1;

  // lowest-index low column wins when several are pressed
  always_comb begin
    low_col = 2'd0;
    if (!sync2[0])      low_col = 2'd0;
    else if (!sync2[1]) low_col = 2'd1;
    else if (!sync2[2]) low_col = 2'd2;
    else if (!sync2[3]) low_col = 2'd3;
  end

  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    cnt_n   = cnt;
    latch   = 1'b0;
    unique case (state)
      SCAN: begin
        if (scan_en) begin
          if (any_low) begin
            col_n = low_col;
            cnt_n = 4'd1;
            if (NCNT == 4'd1) begin
              latch   = 1'b1;
              state_n = HELD;
            end else begin
              state_n = DEBOUNCE;
            end
          end else begin
            row_n = row + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (scan_en) begin
          if (!col_hi) begin
            cnt_n = cnt_inc;
            if (cnt_inc == NCNT) begin
              latch   = 1'b1;
              state_n = HELD;
            end
          end else begin
            state_n = SCAN;
            row_n   = row + 2'd1;
          end
        end
      end
      HELD: begin
        if (scan_en && col_hi) begin
          cnt_n = 4'd1;
          if (NCNT == 4'd1) begin
            state_n = SCAN;
            row_n   = row + 2'd1;
          end else begin
            state_n = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (scan_en) begin
          if (col_hi) begin
            cnt_n = cnt_inc;
            if (cnt_inc == NCNT) begin
              state_n = SCAN;
              row_n   = row + 2'd1;
            end
          end else begin
            state_n = HELD;
          end
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 4'b1111;
      sync2     <= 4'b1111;
      state     <= SCAN;
      row       <= 2'd0;
      col       <= 2'd0;
      cnt       <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync1    <= col_in;
      sync2    <= sync1;
      state    <= state_n;
      row      <= row_n;
      col      <= col_n;
      cnt      <= cnt_n;
      key_down <= (state == HELD) || (state == RELEASE);
      // an ack in the latch clock frees the slot for the new key
      if (latch) begin
        if (!key_valid || key_ack) begin
          key_code  <= {row, col_n};
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_ack && key_valid) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives col_in from
// row_out; a key-level reference model predicts every strobe.
module tb_keypad_scanner;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_en = 1'b0;
  logic [3:0] col_in;
  logic       key_ack = 1'b0;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       overrun;

  logic [15:0] pressed = 16'h0;

  int cmp = 0;
  int err = 0;

  int   mr;
  int   cand;
  int   streak;
  int   rel;
  bit   mheld;
  bit   mvalid;
  bit   movr;
  logic [3:0] mcode;

  keypad_scanner #(.DEBOUNCE_SCANS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .scan_en   (scan_en),
    .col_in    (col_in),
    .key_ack   (key_ack),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // physical matrix: a pressed key shorts its row to its column
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [3:0] got,
                     input logic [3:0] exp);
    cmp++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mr = 0; cand = -1; streak = 0; rel = 0;
    mheld = 0; mvalid = 0; movr = 0; mcode = 4'd0;
  endtask

  task automatic model_strobe(input bit ack);
    int c;
    bit emit;
    c = -1;
    emit = 0;
    if (cand < 0) begin
      for (int i = 3; i >= 0; i--)
        if (pressed[mr*4+i]) c = i;
      if (c >= 0) begin
        cand = mr*4 + c;
        streak = 1;
        if (streak == N) begin emit = 1; mheld = 1; rel = 0; end
      end else begin
        mr = (mr + 1) % 4;
      end
    end else if (!mheld) begin
      if (pressed[cand]) begin
        streak++;
        if (streak == N) begin emit = 1; mheld = 1; rel = 0; end
      end else begin
        cand = -1;
        mr = (mr + 1) % 4;
      end
    end else begin
      if (!pressed[cand]) begin
        rel++;
        if (rel == N) begin
          cand = -1; mheld = 0; mr = (mr + 1) % 4;
        end
      end else begin
        rel = 0;
      end
    end
    if (emit) begin
      if (!mvalid || ack) begin
        mcode = 4'(cand);
        mvalid = 1;
      end else begin
        movr = 1;
      end
    end else if (ack && mvalid) begin
      mvalid = 0;
      movr = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_row"}, row_out, ~(4'b0001 << mr));
    chk({tag, "_valid"}, {3'b0, key_valid}, {3'b0, mvalid});
    chk({tag, "_ovr"}, {3'b0, overrun}, {3'b0, movr});
    chk({tag, "_code"}, key_code, mcode);
  endtask

  task automatic step(input bit ack);
    repeat (2) @(posedge clk);
    chk("key_down", {3'b0, key_down}, {3'b0, mheld});
    #1;
    scan_en = 1'b1;
    key_ack = ack;
    @(posedge clk);
    #1;
    scan_en = 1'b0;
    key_ack = 1'b0;
    model_strobe(ack);
    check_all("step");
  endtask

  task automatic ack_only();
    @(posedge clk);
    #1;
    key_ack = 1'b1;
    @(posedge clk);
    #1;
    key_ack = 1'b0;
    if (mvalid) begin mvalid = 0; movr = 0; end
    check_all("ack");
  endtask

  task automatic press_here(input int c);
    pressed = 16'h0;
    pressed[mr*4+c] = 1'b1;
  endtask

  task automatic async_reset(input string tag);
    #3;
    reset = 1'b1;
    #1;
    chk({tag, "_row"}, row_out, 4'b1110);
    chk({tag, "_valid"}, {3'b0, key_valid}, 4'd0);
    chk({tag, "_down"}, {3'b0, key_down}, 4'd0);
    chk({tag, "_ovr"}, {3'b0, overrun}, 4'd0);
    chk({tag, "_code"}, key_code, 4'd0);
    pressed = 16'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int kb;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_row", row_out, 4'b1110);
    chk("rst_valid", {3'b0, key_valid}, 4'd0);
    chk("rst_ovr", {3'b0, overrun}, 4'd0);
    chk("rst_down", {3'b0, key_down}, 4'd0);
    chk("rst_code", key_code, 4'd0);

    // idle rows cycle
    for (int i = 0; i < 5; i++) step(1'b0);

    // hold row2/col1 -> code 9
    pressed = 16'h0;
    pressed[9] = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0);
    chk("hold9_code", key_code, 4'd9);
    chk("hold9_valid", {3'b0, key_valid}, 4'd1);
    chk("hold9_down", {3'b0, key_down}, 4'd1);
    pressed = 16'h0;
    for (int i = 0; i < N + 1; i++) step(1'b0);
    ack_only();

    // bounce: two strobes low then high
    kb = mr;
    press_here(2);
    step(1'b0);
    step(1'b0);
    pressed = 16'h0;
    step(1'b0);
    chk("bounce_valid", {3'b0, key_valid}, 4'd0);
    chk("bounce_row", row_out, ~(4'b0001 << ((kb + 1) % 4)));

    // two presses without ack -> overrun
    press_here(0);
    for (int i = 0; i < N; i++) step(1'b0);
    kb = mr * 4;
    pressed = 16'h0;
    for (int i = 0; i < N + 1; i++) step(1'b0);
    press_here(3);
    for (int i = 0; i < N; i++) step(1'b0);
    chk("ovr_code", key_code, 4'(kb));
    chk("ovr_flag", {3'b0, overrun}, 4'd1);
    ack_only();
    chk("ovr_ack_valid", {3'b0, key_valid}, 4'd0);
    chk("ovr_ack_flag", {3'b0, overrun}, 4'd0);
    pressed = 16'h0;
    for (int i = 0; i < N + 1; i++) step(1'b0);

    // ack lands in the latch clock of a second key
    press_here(1);
    for (int i = 0; i < N; i++) step(1'b0);
    pressed = 16'h0;
    for (int i = 0; i < N + 1; i++) step(1'b0);
    press_here(2);
    kb = mr * 4 + 2;
    for (int i = 0; i < N - 1; i++) step(1'b0);
    step(1'b1);
    chk("ackl_valid", {3'b0, key_valid}, 4'd1);
    chk("ackl_code", key_code, 4'(kb));
    chk("ackl_ovr", {3'b0, overrun}, 4'd0);
    pressed = 16'h0;
    for (int i = 0; i < N + 1; i++) step(1'b0);
    ack_only();

    // reset during debounce and during held
    press_here(1);
    step(1'b0);
    step(1'b0);
    async_reset("rst_deb");
    for (int i = 0; i < 3; i++) step(1'b0);
    press_here(0);
    for (int i = 0; i < N + 1; i++) step(1'b0);
    async_reset("rst_held");
    step(1'b0);

    // randomized key traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        pressed = 16'h0;
        for (int k = 0; k < int'($urandom_range(0, 2)); k++)
          pressed[$urandom_range(0, 15)] = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) ack_only();
      step($urandom_range(0, 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
